// File: rtl/memory_access_stage_pkg.sv
// Shared encodings for the MEM stage: access sizes, control-bus bit positions, FSM states.
// Also holds the alignment and byte-enable helpers used by the stage.
package memory_access_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int unsigned MEM_READ_BIT     = 0;
    localparam int unsigned MEM_WRITE_BIT    = 1;
    localparam int unsigned MEM_SIZE_LO      = 2;
    localparam int unsigned MEM_SIZE_HI      = 3;
    localparam int unsigned MEM_UNSIGNED_BIT = 4;

    localparam int unsigned WB_REG_WRITE_BIT  = 0;
    localparam int unsigned WB_MEM_TO_REG_BIT = 1;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = a[0];
            SZ_WORD: mis = (a != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << a;
            SZ_HALF: be = 4'b0011 << a;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// Data-memory req/ack port. The stage drives the request side through the master modport;
// the memory (or its model) answers through the slave modport.
interface memory_access_stage_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  dmem_req;
    logic                  dmem_we;
    logic [DATA_WIDTH-1:0] dmem_addr;
    logic [3:0]            dmem_be;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic [DATA_WIDTH-1:0] dmem_rdata;
    logic                  dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/memory_access_stage_load_formatter.sv
// Load data alignment: moves the addressed lane down to bit 0 and sign/zero-extends it
// according to the access size.
module load_formatter
    import memory_access_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            a,
    input  logic [1:0]            size,
    input  logic                  is_unsigned,
    output logic [DATA_WIDTH-1:0] load_data
);

    logic [DATA_WIDTH-1:0] shifted;

    assign shifted = rdata >> {a, 3'b000};

    always_comb begin
        load_data = shifted;
        case (size)
            SZ_BYTE: load_data = is_unsigned ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]}
                                             : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = is_unsigned ? {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]}
                                             : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// Pipeline MEM stage: issues byte/half/word loads and stores over a req/ack port, stalls
// upstream while an access is outstanding, and presents a registered result to writeback.
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned REG_ADDR_BITS = 5,
    parameter int unsigned MEM_BUS_WIDTH = 5,
    parameter int unsigned WB_BUS_WIDTH  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    input  logic [MEM_BUS_WIDTH-1:0] mem_bus_in,
    input  logic [WB_BUS_WIDTH-1:0]  wb_bus_in,
    input  logic [DATA_WIDTH-1:0]    alu_result_in,
    input  logic [DATA_WIDTH-1:0]    store_data_in,
    input  logic [REG_ADDR_BITS-1:0] reg_w_addr_in,
    output logic                     stall_out,
    memory_access_stage_if.master    dmem,
    output logic                     valid_out,
    output logic [WB_BUS_WIDTH-1:0]  wb_bus_out,
    output logic [REG_ADDR_BITS-1:0] reg_w_addr_out,
    output logic [DATA_WIDTH-1:0]    alu_result_out,
    output logic [DATA_WIDTH-1:0]    load_data_out,
    output logic                     misaligned_out
);

    state_e                   state_q;
    logic                     req_q, we_q, uns_q;
    logic [DATA_WIDTH-1:0]    addr_q, wdata_q, alu_q;
    logic [3:0]               be_q;
    logic [1:0]               size_q, a_q;
    logic [WB_BUS_WIDTH-1:0]  wb_q;
    logic [REG_ADDR_BITS-1:0] rd_q;

    logic [1:0]              size, a;
    logic                    is_mem, is_store, mis;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [WB_BUS_WIDTH-1:0] wb_masked;
    logic [DATA_WIDTH-1:0]   fmt_data;

    assign size     = mem_bus_in[MEM_SIZE_HI:MEM_SIZE_LO];
    assign a        = alu_result_in[1:0];
    assign is_mem   = valid_in & (mem_bus_in[MEM_READ_BIT] | mem_bus_in[MEM_WRITE_BIT]);
    // Write wins when both read and write are set.
    assign is_store = mem_bus_in[MEM_WRITE_BIT];
    assign mis      = is_mem & is_misaligned(size, a);

    always_comb begin
        wdata = store_data_in;
        case (size)
            SZ_BYTE: wdata = {(DATA_WIDTH/8){store_data_in[7:0]}};
            SZ_HALF: wdata = {(DATA_WIDTH/16){store_data_in[15:0]}};
            default: wdata = store_data_in;
        endcase
    end

    always_comb begin
        wb_masked = wb_bus_in;
        if (mis) wb_masked[WB_REG_WRITE_BIT] = 1'b0;
    end

    always_comb begin
        stall_out = 1'b0;
        unique case (state_q)
            StIdle:  stall_out = is_mem & ~mis;
            StWait:  stall_out = ~dmem.dmem_ack;
            default: stall_out = 1'b0;
        endcase
    end

    load_formatter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_formatter (
        .rdata       (dmem.dmem_rdata),
        .a           (a_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .load_data   (fmt_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            uns_q          <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            alu_q          <= '0;
            be_q           <= '0;
            size_q         <= SZ_BYTE;
            a_q            <= '0;
            wb_q           <= '0;
            rd_q           <= '0;
            valid_out      <= 1'b0;
            wb_bus_out     <= '0;
            reg_w_addr_out <= '0;
            alu_result_out <= '0;
            load_data_out  <= '0;
            misaligned_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (is_mem && !mis) begin
                        state_q <= StWait;
                        req_q   <= 1'b1;
                        we_q    <= is_store;
                        uns_q   <= mem_bus_in[MEM_UNSIGNED_BIT];
                        addr_q  <= {alu_result_in[DATA_WIDTH-1:2], 2'b00};
                        wdata_q <= wdata;
                        alu_q   <= alu_result_in;
                        be_q    <= byte_enables(size, a);
                        size_q  <= size;
                        a_q     <= a;
                        wb_q    <= wb_bus_in;
                        rd_q    <= reg_w_addr_in;
                    end else if (valid_in) begin
                        // Non-memory and misaligned ops retire straight away.
                        valid_out      <= 1'b1;
                        misaligned_out <= mis;
                        wb_bus_out     <= wb_masked;
                        reg_w_addr_out <= reg_w_addr_in;
                        alu_result_out <= alu_result_in;
                        load_data_out  <= '0;
                    end
                end
                StWait: begin
                    if (dmem.dmem_ack) begin
                        state_q        <= StIdle;
                        req_q          <= 1'b0;
                        valid_out      <= 1'b1;
                        misaligned_out <= 1'b0;
                        wb_bus_out     <= wb_q;
                        reg_w_addr_out <= rd_q;
                        alu_result_out <= alu_q;
                        load_data_out  <= we_q ? '0 : fmt_data;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;

endmodule
